// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronises N raw slide-switch pins to clk, debounces
// each bit independently and produces a clean level bus and one-cycle edge
// pulses.
// Optional build macro SWDB_EVENT_CNT_EN adds an 8-bit wrapping event counter
// output (event_cnt) that increments once per cycle with sw_changed high.
module switch_debouncer #(
  parameter int N             = 16,
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  output logic [N-1:0] sw_db,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall,
`ifdef SWDB_EVENT_CNT_EN
  output logic [7:0]   event_cnt,
`endif
  output logic         sw_changed
);

  // Count value at which a differing synchronised level is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N-1:0]            s1_q, s1_d;
  logic [N-1:0]            s2_q, s2_d;
  logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]            db_q, db_d;
  logic [N-1:0]            rise_q, rise_d;
  logic [N-1:0]            fall_q, fall_d;
  logic                    changed_q, changed_d;

  // Two-flop synchroniser chain: plain wires between stages, no logic.
  always_comb begin
    s1_d = sw;
    s2_d = s1_q;
  end

  // Per-bit debounce: count consecutive cycles that the synchronised level
  // differs from the accepted level; any return to the accepted level drops
  // the count to zero so a bounce earns no partial credit.
  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < N; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]   = s2_q[i];
        cnt_d[i]  = '0;
        rise_d[i] = s2_q[i];
        fall_d[i] = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  // State registers; reset clears synchroniser, counters, levels and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      cnt_q     <= '0;
      db_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign sw_db      = db_q;
  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign sw_changed = changed_q;

`ifdef SWDB_EVENT_CNT_EN
  logic [7:0] event_cnt_q, event_cnt_d;

  // One count per cycle with any edge pulse, independent of how many bits
  // changed; wraps naturally at 8 bits.
  always_comb begin
    event_cnt_d = event_cnt_q + {7'd0, changed_q};
  end

  // Event counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_cnt_q <= '0;
    end else begin
      event_cnt_q <= event_cnt_d;
    end
  end

  assign event_cnt = event_cnt_q;
`endif

endmodule
